line_edit: RTL and testbench

LINE_EDIT -- requirements
Module: line_edit

---
 rtl/line_edit.sv | 186 ++++++++++++++++++
 tb/tb_line_edit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/line_edit.sv
// line_edit: interactive line editor between a UART receiver and transmitter.
// Printable bytes are stored and echoed, backspace/DEL erase the last byte,
// CR completes the line and holds it for a consumer until line_ack.
//
// state | meaning
// IDLE  | waiting for a received byte
// ECHO  | 1-3 echo bytes queued toward the transmitter
// HOLD  | completed line held, line_valid=1, buffer frozen
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_data/rx_rdy      received byte and its one-cycle strobe
//   rx_break            break from receiver: abandons the line and any echo
//   tx_data/tx_wr       echo byte and write request; transfer when !tx_busy
//   tx_busy             transmitter busy
//   line_valid          a completed line is held
//   line_len            number of stored bytes
//   line_ack            consumer releases the held line
//   rd_addr/rd_data     buffer read port, one cycle latency
//   overrun             sticky: a byte arrived while not in IDLE
module line_edit #(
  parameter int LINE_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  input  logic       rx_break,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_busy,
  output logic       line_valid,
  output logic [7:0] line_len,
  input  logic       line_ack,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       overrun
);

  localparam int         AW   = $clog2(LINE_LEN);
  localparam logic [7:0] LEN8 = 8'(LINE_LEN);

  typedef enum logic [1:0] {IDLE, ECHO, HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_wr_q, tx_wr_d;
  logic [7:0]  rem0_q, rem0_d, rem1_q, rem1_d;
  logic [1:0]  rem_cnt_q, rem_cnt_d;
  logic        cr_q, cr_d;
  logic [7:0]  line_len_q, line_len_d;
  logic        line_valid_q, line_valid_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        wr_en;
  logic [7:0]  mem_q [LINE_LEN];

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_wr_d    = tx_wr_q;
    rem0_d     = rem0_q;
    rem1_d     = rem1_q;
    rem_cnt_d  = rem_cnt_q;
    cr_d       = cr_q;
    line_len_d = line_len_q;
    overrun_d  = overrun_q;
    wr_en      = 1'b0;
    rd_data_d  = (rd_addr < LEN8) ? mem_q[rd_addr[AW-1:0]] : 8'h00;

    if (rx_break) begin
      state_d    = IDLE;
      tx_wr_d    = 1'b0;
      rem_cnt_d  = 2'd0;
      cr_d       = 1'b0;
      line_len_d = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_rdy) begin
            // tx_data_d/rem/cnt loaded per byte class; any echo moves to ECHO
            if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
              if (line_len_q < LEN8) begin
                wr_en      = 1'b1;
                line_len_d = line_len_q + 8'd1;
                tx_data_d  = rx_data;
              end else begin
                tx_data_d  = 8'h07;
              end
              rem_cnt_d = 2'd0;
              tx_wr_d   = 1'b1;
              state_d   = ECHO;
            end else if (rx_data == 8'h08 || rx_data == 8'h7F) begin
              if (line_len_q != 8'd0) begin
                line_len_d = line_len_q - 8'd1;
                tx_data_d  = 8'h08;
                rem0_d     = 8'h20;
                rem1_d     = 8'h08;
                rem_cnt_d  = 2'd2;
              end else begin
                tx_data_d  = 8'h07;
                rem_cnt_d  = 2'd0;
              end
              tx_wr_d = 1'b1;
              state_d = ECHO;
            end else if (rx_data == 8'h0D) begin
              tx_data_d = 8'h0D;
              rem0_d    = 8'h0A;
              rem_cnt_d = 2'd1;
              cr_d      = 1'b1;
              tx_wr_d   = 1'b1;
              state_d   = ECHO;
            end
          end
        end
        ECHO: begin
          if (rx_rdy) overrun_d = 1'b1;
          if (!tx_busy) begin
            if (rem_cnt_q != 2'd0) begin
              tx_data_d = rem0_q;
              rem0_d    = rem1_q;
              rem_cnt_d = rem_cnt_q - 2'd1;
            end else begin
              tx_wr_d = 1'b0;
              cr_d    = 1'b0;
              state_d = cr_q ? HOLD : IDLE;
            end
          end
        end
        HOLD: begin
          if (rx_rdy) overrun_d = 1'b1;
          if (line_ack) begin
            state_d    = IDLE;
            line_len_d = 8'd0;
            // a byte arriving on the release cycle was still dropped
            overrun_d  = rx_rdy;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    line_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_data_q    <= 8'h00;
      tx_wr_q      <= 1'b0;
      rem0_q       <= 8'h00;
      rem1_q       <= 8'h00;
      rem_cnt_q    <= 2'd0;
      cr_q         <= 1'b0;
      line_len_q   <= 8'd0;
      line_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_wr_q      <= tx_wr_d;
      rem0_q       <= rem0_d;
      rem1_q       <= rem1_d;
      rem_cnt_q    <= rem_cnt_d;
      cr_q         <= cr_d;
      line_len_q   <= line_len_d;
      line_valid_q <= line_valid_d;
      overrun_q    <= overrun_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Buffer storage is not reset; only line_len defines valid contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[line_len_q[AW-1:0]] <= rx_data;
  end

  assign tx_data    = tx_data_q;
  assign tx_wr      = tx_wr_q;
  assign line_valid = line_valid_q;
  assign line_len   = line_len_q;
  assign overrun    = overrun_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_line_edit.sv
module tb_line_edit;
  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy = 1'b0;
  logic       rx_break = 1'b0;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy = 1'b0;
  logic       line_valid;
  logic [7:0] line_len;
  logic       line_ack = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic       overrun;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  line_edit #(.LINE_LEN(LEN)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .rx_break(rx_break), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_busy(tx_busy), .line_valid(line_valid), .line_len(line_len),
    .line_ack(line_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard: a transfer happens on the next rising edge when tx_wr && !tx_busy.
  always @(negedge clk) begin
    if (!rst && tx_wr === 1'b1 && tx_busy === 1'b0) begin
      if (exp_q.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'h1FF);
      else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    step();
    rx_rdy  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || tx_wr) && n < 100) begin
      step();
      n++;
    end
    chk("idle_timeout", (n < 100), 1);
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] e);
    rd_addr = a;
    step();
    chk("rd_data", {24'h0, rd_data}, {24'h0, e});
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_tx_wr"}, tx_wr, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_line_valid"}, line_valid, 0);
    chk({tag, "_line_len"}, line_len, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = 8'd1;
    step(); step();
    rst = 1'b0;
    reset_chk("reset");

    // "AB" CR -> 41 42 0D 0A, then HOLD
    exp_q.push_back(8'h41); send(8'h41); wait_idle();
    exp_q.push_back(8'h42); send(8'h42); wait_idle();
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); send(8'h0D); wait_idle();
    chk("hold_valid", line_valid, 1);
    chk("hold_len", line_len, 2);
    rd_chk(8'd0, 8'h41);
    rd_chk(8'd1, 8'h42);
    rd_chk(8'd7, 8'h00);

    // byte during HOLD is dropped, then release
    send(8'h5A);
    step();
    chk("hold_drop_overrun", overrun, 1);
    chk("hold_drop_len", line_len, 2);
    chk("hold_drop_valid", line_valid, 1);
    chk("hold_drop_tx", tx_wr, 0);
    line_ack = 1'b1; step(); line_ack = 1'b0;
    chk("ack_valid", line_valid, 0);
    chk("ack_len", line_len, 0);
    chk("ack_overrun", overrun, 0);

    // backspace and DEL on empty line
    exp_q.push_back(8'h41); send(8'h41); wait_idle();
    exp_q.push_back(8'h08); exp_q.push_back(8'h20); exp_q.push_back(8'h08);
    send(8'h08); wait_idle();
    chk("bs_len", line_len, 0);
    exp_q.push_back(8'h07); send(8'h7F); wait_idle();
    chk("del_empty_len", line_len, 0);

    // fill to capacity, fifth byte rings bell
    exp_q.push_back(8'h77); send(8'h77); wait_idle();
    exp_q.push_back(8'h78); send(8'h78); wait_idle();
    exp_q.push_back(8'h79); send(8'h79); wait_idle();
    exp_q.push_back(8'h7A); send(8'h7A); wait_idle();
    exp_q.push_back(8'h07); send(8'h51); wait_idle();
    chk("full_len", line_len, 4);
    rd_chk(8'd0, 8'h77);
    rd_chk(8'd1, 8'h78);
    rd_chk(8'd2, 8'h79);
    rd_chk(8'd3, 8'h7A);
    rd_chk(8'd4, 8'h00);

    // control byte ignored
    send(8'h01); step(); step();
    chk("ignore_tx", tx_wr, 0);
    chk("ignore_len", line_len, 4);

    // break clears the line, overrun untouched (0 here)
    rx_break = 1'b1; step(); rx_break = 1'b0;
    chk("brk1_len", line_len, 0);
    chk("brk1_overrun", overrun, 0);

    // transmitter busy: tx_wr and tx_data held
    tx_busy = 1'b1;
    exp_q.push_back(8'h43); send(8'h43);
    for (int i = 0; i < 10; i++) begin
      chk("busy_tx_wr", tx_wr, 1);
      chk("busy_tx_data", tx_data, 8'h43);
      step();
    end
    send(8'h44);
    chk("echo_drop_overrun", overrun, 1);
    tx_busy = 1'b0;
    wait_idle();
    chk("busy_len", line_len, 1);

    // break mid-echo of 08 20 08
    exp_q.push_back(8'h45); send(8'h45); wait_idle();
    tx_busy = 1'b1;
    send(8'h08);
    chk("bs_pending_wr", tx_wr, 1);
    chk("bs_pending_len", line_len, 1);
    rx_break = 1'b1; step(); rx_break = 1'b0;
    chk("brk2_tx_wr", tx_wr, 0);
    chk("brk2_len", line_len, 0);
    chk("brk2_valid", line_valid, 0);
    chk("brk2_overrun", overrun, 1);
    tx_busy = 1'b0;
    step(); step();
    chk("brk2_quiet", tx_wr, 0);

    // ack clears overrun; later ack with simultaneous rx_rdy sets it
    exp_q.push_back(8'h47); send(8'h47); wait_idle();
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); send(8'h0D); wait_idle();
    line_ack = 1'b1; step(); line_ack = 1'b0;
    chk("ack2_overrun", overrun, 0);
    exp_q.push_back(8'h48); send(8'h48); wait_idle();
    line_ack = 1'b1; step(); line_ack = 1'b0;
    chk("ack_outside_len", line_len, 1);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); send(8'h0D); wait_idle();
    chk("hold2_valid", line_valid, 1);
    line_ack = 1'b1; rx_data = 8'h49; rx_rdy = 1'b1;
    step();
    line_ack = 1'b0; rx_rdy = 1'b0;
    chk("ack_rdy_overrun", overrun, 1);
    chk("ack_rdy_len", line_len, 0);
    chk("ack_rdy_valid", line_valid, 0);
    step();
    chk("ack_rdy_tx", tx_wr, 0);

    // reset while holding a line
    exp_q.push_back(8'h49); send(8'h49); wait_idle();
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); send(8'h0D); wait_idle();
    chk("hold3_valid", line_valid, 1);
    rd_addr = 8'd0; step();
    rst = 1'b1; step(); rst = 1'b0;
    reset_chk("rst_hold");

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
